// File: rtl/decoder_seq_pkg.sv
// -----------------------------------------------------------------------------
// decoder_seq_pkg
// Shared types and constants for the sequential one-hot decoder.
//   state_e      : controller state (IDLE, DIRECT, SWEEP)
//   MODE_DIRECT  : mode input value selecting externally supplied codes
//   MODE_SWEEP   : mode input value selecting the self-driven code sweep
//   step_cnt_width() : width of the per-code step counter for a given STEP
// -----------------------------------------------------------------------------
package decoder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SWEEP  = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

    // A STEP of 1 still needs a 1-bit counter so the port/flop never collapses
    // to zero width.
    function automatic int step_cnt_width(input int step);
        return (step <= 32'sd1) ? 32'sd1 : $clog2(step);
    endfunction

endpackage

// File: rtl/decoder_shift_core.sv
// -----------------------------------------------------------------------------
// decoder_shift_core
// Purely combinational N-to-2**N decoder: onehot = 1 << code.
//   code   in  N      binary code
//   onehot out 2**N   one-hot image of code
// -----------------------------------------------------------------------------
module decoder_shift_core #(
    parameter int N = 4
) (
    input  logic [N-1:0]      code,
    output logic [(2**N)-1:0] onehot
);

    localparam int W = 2**N;

    // Shift a single set bit into the position named by code.
    always_comb begin
        onehot = {{(W-1){1'b0}}, 1'b1} << code;
    end

endmodule

// File: rtl/decoder_seq_sweep.sv
// -----------------------------------------------------------------------------
// decoder_seq_sweep
// Registered N-to-2**N one-hot decoder with valid/ready on both sides and a
// self-driven sweep mode that emits every code in order, one per STEP cycles.
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   en         in   block enable; dropping it returns the block to IDLE
//   mode       in   0 = DIRECT, 1 = SWEEP, sampled only in IDLE
//   in_valid   in   in_code is valid (DIRECT only)
//   in_code    in   code to decode
//   in_ready   out  in_code is accepted this cycle when in_valid is high
//   out_valid  out  result slot holds a result
//   out_ready  in   consumer takes the result this cycle
//   out_onehot out  one-hot result (bit out_code set)
//   out_code   out  code that produced out_onehot
//   out_last   out  sweep result is the final code 2**N-1
// -----------------------------------------------------------------------------
module decoder_seq_sweep
    import decoder_seq_pkg::*;
#(
    parameter int N    = 4,
    parameter int STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [N-1:0]      in_code,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [(2**N)-1:0] out_onehot,
    output logic [N-1:0]      out_code,
    output logic              out_last
);

    localparam int              W         = 2**N;
    localparam int              SW        = step_cnt_width(STEP);
    localparam logic [SW-1:0]   STEP_LAST = SW'(STEP - 1);
    localparam logic [N-1:0]    CODE_MAX  = {N{1'b1}};

    state_e          state_q,     state_d;
    logic [N-1:0]    sweep_cnt_q, sweep_cnt_d;
    logic [SW-1:0]   step_cnt_q,  step_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_onehot_q, out_onehot_d;
    logic [N-1:0]    out_code_q,  out_code_d;
    logic            out_last_q,  out_last_d;

    logic            slot_free_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            step_done_s;
    logic            emit_s;
    logic            sweep_start_s;
    logic [N-1:0]    core_code_s;
    logic [W-1:0]    core_onehot_s;

    // Single shared decoder; its input is steered by the active mode.
    decoder_shift_core #(
        .N (N)
    ) u_core (
        .code   (core_code_s),
        .onehot (core_onehot_s)
    );

    // Handshake qualifiers: the slot can take a new result when it is empty
    // or being drained this cycle, so back-to-back transfers have no bubble.
    always_comb begin
        slot_free_s   = !out_valid_q || out_ready;
        in_ready_s    = (state_q == DIRECT) && en && slot_free_s;
        accept_s      = in_ready_s && in_valid;
        step_done_s   = (step_cnt_q == STEP_LAST);
        emit_s        = (state_q == SWEEP) && en && slot_free_s && step_done_s;
        sweep_start_s = (state_q == IDLE) && en && (mode == MODE_SWEEP);
        if (state_q == SWEEP) begin
            core_code_s = sweep_cnt_q;
        end else begin
            core_code_s = in_code;
        end
    end

    // Controller: mode is only looked at in IDLE; en low always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (mode == MODE_SWEEP) begin
                        state_d = SWEEP;
                    end else begin
                        state_d = DIRECT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIRECT, SWEEP: begin
                if (en) begin
                    state_d = state_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sweep counters: both freeze under backpressure so no code is skipped.
    always_comb begin
        sweep_cnt_d = sweep_cnt_q;
        step_cnt_d  = step_cnt_q;
        if (sweep_start_s) begin
            sweep_cnt_d = {N{1'b0}};
            step_cnt_d  = {SW{1'b0}};
        end else if ((state_q == SWEEP) && en && slot_free_s) begin
            if (step_done_s) begin
                sweep_cnt_d = sweep_cnt_q + N'(1);
                step_cnt_d  = {SW{1'b0}};
            end else begin
                sweep_cnt_d = sweep_cnt_q;
                step_cnt_d  = step_cnt_q + SW'(1);
            end
        end else begin
            sweep_cnt_d = sweep_cnt_q;
            step_cnt_d  = step_cnt_q;
        end
    end

    // Result slot: load on accept/emit, otherwise drain on out_ready, otherwise
    // hold everything stable.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_onehot_d = out_onehot_q;
        out_code_d   = out_code_q;
        out_last_d   = out_last_q;
        if (accept_s || emit_s) begin
            out_valid_d  = 1'b1;
            out_onehot_d = core_onehot_s;
            out_code_d   = core_code_s;
            if (emit_s) begin
                out_last_d = (sweep_cnt_q == CODE_MAX);
            end else begin
                out_last_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sweep_cnt_q  <= {N{1'b0}};
            step_cnt_q   <= {SW{1'b0}};
            out_valid_q  <= 1'b0;
            out_onehot_q <= {W{1'b0}};
            out_code_q   <= {N{1'b0}};
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_cnt_q  <= sweep_cnt_d;
            step_cnt_q   <= step_cnt_d;
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            out_code_q   <= out_code_d;
            out_last_q   <= out_last_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_code   = out_code_q;
    assign out_last   = out_last_q;

endmodule

// File: doc/decoder_seq_sweep.md
# decoder_seq_sweep

Registered, parametrised N-to-2^N one-hot decoder with a valid/ready handshake on both sides and a self-driven sweep mode that steps through every code in order. It is the sequential successor to the fixed 4-to-16 shift decoder. It sits between a code producer (or nothing, in sweep mode) and one-hot select consumers: bank selects, LED/segment scanners, and bench stimulus.

## Interface
Parameters:
- N, 4, code width; output width is 2**N; legal range 1..8.
- STEP, 1, clock cycles per code in sweep mode; legal range ≥1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- en  in  1  block enable.
- mode  in  1  0 = DIRECT, 1 = SWEEP; sampled only in IDLE.
- in_valid  in  1  in_code is valid (DIRECT only).
- in_code  in  N  code to decode.
- in_ready  out  1  block accepts in_code this cycle.
- out_valid  out  1  out_onehot/out_code hold a result.
- out_ready  in  1  consumer accepts result this cycle.
- out_onehot  out  2**N  one-hot result, bit out_code set.
- out_code  out  N  code that produced out_onehot.
- out_last  out  1  qualifies out_valid: the sweep result is code 2**N-1.

## Operation
- **Reset** (rst_n=0 at an edge): state=IDLE, out_valid=0, out_onehot=0, out_code=0, out_last=0, sweep_cnt=0, step_cnt=0. Reset mid-transfer discards any held result.
- **Output slot:** one entry. slot_free = !out_valid || out_ready.
- **IDLE:**
  - in_ready=0.
  - en=1 with mode=0 → DIRECT; en=1 with mode=1 → SWEEP.
  - Entering SWEEP clears sweep_cnt and step_cnt.
- **DIRECT:**
  - in_ready = slot_free.
  - Accept on in_valid && in_ready. Next edge: out_onehot = 1<<in_code, out_code = in_code, out_valid=1, out_last=0.
  - If slot_free and there is no accept, out_valid clears.
- **SWEEP:**
  - in_ready=0; in_code is ignored.
  - step_cnt advances only when slot_free.
  - When step_cnt==STEP-1 and slot_free: emit sweep_cnt (onehot, code, out_valid=1), set out_last = (sweep_cnt==2**N-1), increment sweep_cnt mod 2**N (wrap to 0), and set step_cnt=0.
  - Otherwise, if slot_free, out_valid clears.
- **en=0 in DIRECT or SWEEP:**
  - Next state is IDLE.
  - No new accept or emission occurs on that edge.
  - A held result stays valid and stable until out_ready.
- **Mode changes:** a change of mode while in DIRECT or SWEEP is ignored until the block returns to IDLE.
- **Stability:** out_onehot, out_code and out_last are stable while out_valid && !out_ready. Whenever out_valid=1, out_onehot has exactly one bit set.

## Timing
- DIRECT latency: 1 cycle from accept edge to out_valid. Full throughput of 1 code/cycle when out_ready=1.
- SWEEP rate: one code per STEP cycles with out_ready held 1.
  - First code (0) appears STEP cycles after the IDLE→SWEEP edge.
  - Full period is STEP·2**N cycles.
- Backpressure in SWEEP freezes step_cnt and sweep_cnt. No code is skipped or repeated.
- Simultaneous out_ready and new accept/emission in the same cycle: the old result is consumed and the new one is loaded at the same edge. There is no bubble.
- IDLE→active takes 1 cycle; the en sample and state update share one edge.

## Structure
- Package decoder_seq_pkg contains:
  - state enum {IDLE, DIRECT, SWEEP};
  - MODE_DIRECT=1'b0 and MODE_SWEEP=1'b1.
- Sub-module decoder_shift_core (combinational, parameter N): code → 1<<code. It is instantiated once. Its mux input is in_code in DIRECT and sweep_cnt in SWEEP.
- step_cnt width is $clog2(STEP) with a minimum of 1 bit.

## Test plan
- **Reset:** N=4, assert rst_n=0 mid-sweep for 1 cycle → next edge out_valid=0, out_onehot=16'h0000, out_code=0; re-enabling SWEEP restarts at code 0.
- **DIRECT stream:** in_code 0..15 back-to-back, out_ready=1 → out_onehot 16'h0001..16'h8000 each one cycle after accept; in_ready stays 1.
- **DIRECT backpressure:** in_code=4'hA accepted, out_ready=0 for 3 cycles → out_onehot=16'h0400 held, in_ready=0; on release it is accepted, and a queued 4'h3 gives 16'h0008 next cycle.
- **SWEEP wrap:** STEP=2, out_ready=1 → codes 0,1,…,15,0 spaced 2 cycles apart; out_last=1 only with out_onehot=16'h8000; period is 32 cycles.
- **SWEEP stall:** hold out_ready=0 for 5 cycles while code 7 is valid → code 7 is held, then 8 follows after STEP cycles; no code is skipped.
- **en drop / mode change:**
  - Drop en while code 5 is held unaccepted → code 5 stays until out_ready, state goes to IDLE, and no code 6 appears.
  - Toggling mode during DIRECT has no effect until the block passes through IDLE.
